// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and constants for the full-speed UTM transmit and receive paths.
package usb_utmi_pkg;

    typedef logic [7:0] bus8_t;

    // Encoded as {dp, dn}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } utmi_line_state_t;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SYNC    = 3'd1,
        TX_DATA    = 3'd2,
        TX_EOP_SE0 = 3'd3,
        TX_EOP_J   = 3'd4
    } tx_state_t;

    localparam bus8_t       USB_SYNC_PATTERN = 8'h80;
    localparam int unsigned USB_STUFF_BITS_N = 6;
    localparam int unsigned USB_EOP_SE0_BITS = 2;
    localparam int unsigned USB_EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_utm_tx_bitenc.sv
// Bit stuffer and NRZI encoder; registers the D+/D- drive values.
module usb_utm_tx_bitenc
    import usb_utmi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_bit,
    input  logic i_bit_valid,
    input  logic i_force_se0,
    input  logic i_force_j,
    output logic o_dp,
    output logic o_dn,
    output logic o_stall_c
);

    localparam int unsigned OW = 3;

    logic [OW-1:0]    r_ones;
    utmi_line_state_t r_lvl;
    utmi_line_state_t r_line;
    utmi_line_state_t w_lvl_tog;

    // A slot issued while six ones are outstanding becomes a stuffed 0
    assign o_stall_c = (r_ones == OW'(USB_STUFF_BITS_N));
    assign w_lvl_tog = (r_lvl == LS_J) ? LS_K : LS_J;
    assign o_dp      = r_line[1];
    assign o_dn      = r_line[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= '0;
            r_lvl  <= LS_J;
            r_line <= LS_J;
        end else if (i_force_se0) begin
            r_line <= LS_SE0;
            r_ones <= '0;
        end else if (i_force_j) begin
            r_line <= LS_J;
            r_lvl  <= LS_J;
            r_ones <= '0;
        end else if (i_bit_valid) begin
            if (o_stall_c || !i_bit) begin
                r_lvl  <= w_lvl_tog;
                r_line <= w_lvl_tog;
                r_ones <= '0;
            end else begin
                r_line <= r_lvl;
                r_ones <= r_ones + OW'(1);
            end
        end
    end

endmodule

// File: rtl/usb_utm_tx.sv
// Full-speed UTM transmitter: SYNC, byte serializer, stuffing/NRZI via bitenc, EOP.
module usb_utm_tx
    import usb_utmi_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  suspend_m,
    input  bus8_t data_in,
    input  logic  tx_valid,
    output logic  tx_ready,
    output logic  dp_tx,
    output logic  dn_tx,
    output logic  tx_oe
);

    localparam int unsigned CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_PER_BIT - 2);

    tx_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    bus8_t         r_shift, w_shift_nxt;
    logic [BW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic          r_tx_oe, w_tx_oe_nxt;
    logic          r_tx_ready, w_tx_ready_nxt;
    logic          w_enc_bit, w_enc_valid, w_force_se0, w_force_j, w_stall;
    logic          w_strobe, w_pre_strobe, w_byte_done;

    assign w_strobe     = (r_cnt == CNT_LAST);
    assign w_pre_strobe = (r_cnt == CNT_PRE);
    assign w_byte_done  = (r_bit_cnt == BW'(8));

    assign tx_ready = r_tx_ready;
    assign tx_oe    = r_tx_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tx_oe    <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_oe    <= w_tx_oe_nxt;
            r_tx_ready <= w_tx_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_strobe ? '0 : r_cnt + CW'(1);
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_oe_nxt    = r_tx_oe;
        w_tx_ready_nxt = 1'b0;
        w_enc_bit      = r_shift[0];
        w_enc_valid    = 1'b0;
        w_force_se0    = 1'b0;
        w_force_j      = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_cnt_nxt   = '0;
                w_tx_oe_nxt = 1'b0;
                w_force_j   = 1'b1;
                if (tx_valid && suspend_m) begin
                    // First SYNC bit goes out on the same edge that enables the driver
                    w_state_nxt   = TX_SYNC;
                    w_tx_oe_nxt   = 1'b1;
                    w_force_j     = 1'b0;
                    w_enc_valid   = 1'b1;
                    w_enc_bit     = USB_SYNC_PATTERN[0];
                    w_shift_nxt   = USB_SYNC_PATTERN >> 1;
                    w_bit_cnt_nxt = BW'(1);
                end
            end
            TX_SYNC, TX_DATA: begin
                // tx_ready is raised for the boundary strobe cycle itself, so decide one clk early
                if (w_pre_strobe && w_byte_done && !w_stall && tx_valid) begin
                    w_tx_ready_nxt = 1'b1;
                end
                if (w_strobe) begin
                    if (w_stall) begin
                        w_enc_valid = 1'b1;
                    end else if (!w_byte_done) begin
                        w_enc_valid   = 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end else if (r_tx_ready) begin
                        w_state_nxt   = TX_DATA;
                        w_enc_valid   = 1'b1;
                        w_enc_bit     = data_in[0];
                        w_shift_nxt   = data_in >> 1;
                        w_bit_cnt_nxt = BW'(1);
                    end else begin
                        w_state_nxt   = TX_EOP_SE0;
                        w_force_se0   = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            TX_EOP_SE0: begin
                w_force_se0 = 1'b1;
                if (w_strobe) begin
                    if (r_bit_cnt == BW'(USB_EOP_SE0_BITS - 1)) begin
                        w_state_nxt   = TX_EOP_J;
                        w_force_se0   = 1'b0;
                        w_force_j     = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            TX_EOP_J: begin
                w_force_j = 1'b1;
                if (w_strobe) begin
                    if (r_bit_cnt == BW'(USB_EOP_J_BITS - 1)) begin
                        w_state_nxt   = TX_IDLE;
                        w_tx_oe_nxt   = 1'b0;
                        w_cnt_nxt     = '0;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    usb_utm_tx_bitenc u_bitenc (
        .clk         (clk),
        .rst         (rst),
        .i_bit       (w_enc_bit),
        .i_bit_valid (w_enc_valid),
        .i_force_se0 (w_force_se0),
        .i_force_j   (w_force_j),
        .o_dp        (dp_tx),
        .o_dn        (dn_tx),
        .o_stall_c   (w_stall)
    );

endmodule

// File: tb/tb_usb_utm_tx.sv
// Scoreboard bench for usb_utm_tx: line symbols per bit time and tx_ready cycle positions.
module tb_usb_utm_tx;
    import usb_utmi_pkg::*;

    localparam int CPB = 4;
    localparam logic [1:0] SJ = 2'b10;
    localparam logic [1:0] SK = 2'b01;
    localparam logic [1:0] S0 = 2'b00;

    logic  clk = 1'b0;
    logic  rst, suspend_m, tx_valid, tx_ready, dp_tx, dn_tx, tx_oe;
    bus8_t data_in;

    always #5 clk = ~clk;

    usb_utm_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .suspend_m (suspend_m),
        .data_in   (data_in),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dp_tx     (dp_tx),
        .dn_tx     (dn_tx),
        .tx_oe     (tx_oe)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic [1:0] exp_sym_q[$];
    int         exp_rdy_q[$];
    bit         mon_en = 1'b1;
    int         k = 0;
    logic [1:0] cur_sym = 2'b10;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tog(input logic [1:0] s);
        return (s == SJ) ? SK : SJ;
    endfunction

    task automatic emit_bit(input logic v, inout logic [1:0] lvl, inout int ones);
        if (!v) lvl = tog(lvl);
        exp_sym_q.push_back(lvl);
        ones = v ? ones + 1 : 0;
        if (ones == 6) begin
            lvl = tog(lvl);
            exp_sym_q.push_back(lvl);
            ones = 0;
        end
    endtask

    // Reference line sequence: SYNC, stuffed NRZI data, SE0 SE0 J
    task automatic push_expected(input bus8_t b0, input bus8_t b1, input bus8_t b2, input int n);
        logic [1:0] lvl = SJ;
        int         ones = 0;
        bus8_t      bytes[3];
        bus8_t      sync = 8'h80;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        for (int i = 0; i < 8; i++) emit_bit(sync[i], lvl, ones);
        for (int j = 0; j < n; j++)
            for (int i = 0; i < 8; i++) emit_bit(bytes[j][i], lvl, ones);
        exp_sym_q.push_back(S0);
        exp_sym_q.push_back(S0);
        exp_sym_q.push_back(SJ);
    endtask

    task automatic send_pkt(input bus8_t b0, input bus8_t b1, input bus8_t b2, input int n,
                            input int r0, input int r1, input int r2);
        bus8_t bytes[3];
        int    rdy[3];
        int    t;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
        push_expected(b0, b1, b2, n);
        for (int i = 0; i < n; i++) exp_rdy_q.push_back(rdy[i]);
        @(posedge clk); #1;
        data_in  = bytes[0];
        tx_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!tx_ready && t < 300);
            if (!tx_ready) check("ready_timeout", 0, 1);
            @(posedge clk); #1;
            if (i == n - 1) tx_valid = 1'b0;
            else data_in = bytes[i + 1];
        end
        t = 0;
        while (tx_oe && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (tx_oe) check("oe_fall_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Monitor: one symbol per bit time while the driver is enabled
    always @(negedge clk) begin
        if (tx_oe) begin
            if (mon_en) begin
                k++;
                if ((k - 1) % CPB == 0) begin
                    if (exp_sym_q.size() == 0) begin
                        check("sym_underflow", k, 0);
                        cur_sym = 2'b11;
                    end else begin
                        cur_sym = exp_sym_q.pop_front();
                    end
                end
                check("line", int'({dp_tx, dn_tx}), int'(cur_sym));
                if (tx_ready) begin
                    if (exp_rdy_q.size() == 0) check("ready_extra", k, 0);
                    else check("ready_cycle", k, exp_rdy_q.pop_front());
                end
            end
        end else begin
            if (k != 0 && mon_en) begin
                check("sym_left", exp_sym_q.size(), 0);
                check("ready_left", exp_rdy_q.size(), 0);
            end
            if (!mon_en) begin
                exp_sym_q.delete();
                exp_rdy_q.delete();
            end
            k = 0;
            check("idle_line", int'({dp_tx, dn_tx}), int'(SJ));
            check("idle_ready", int'(tx_ready), 0);
        end
    end

    initial begin
        rst       = 1'b1;
        suspend_m = 1'b1;
        tx_valid  = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("reset_oe", int'(tx_oe), 0);
        end

        send_pkt(8'hD2, 8'h00, 8'h00, 1, 32, 0, 0);
        send_pkt(8'hFF, 8'hFF, 8'h00, 2, 32, 68, 0);
        send_pkt(8'hFC, 8'h00, 8'h00, 1, 32, 0, 0);
        send_pkt(8'h00, 8'h00, 8'h00, 3, 32, 64, 96);

        // Suspended: a pending tx_valid must not start a packet
        suspend_m = 1'b0;
        tx_valid  = 1'b1;
        data_in   = 8'h3C;
        repeat (20) begin
            @(negedge clk);
            check("suspend_oe", int'(tx_oe), 0);
        end
        tx_valid  = 1'b0;
        suspend_m = 1'b1;
        @(negedge clk);

        // Reset in the middle of the first data byte, then a clean packet
        mon_en = 1'b0;
        @(posedge clk); #1;
        data_in  = 8'h55;
        tx_valid = 1'b1;
        repeat (45) @(negedge clk);
        check("abort_pre_oe", int'(tx_oe), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_oe", int'(tx_oe), 0);
        check("abort_line", int'({dp_tx, dn_tx}), int'(SJ));
        check("abort_ready", int'(tx_ready), 0);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        send_pkt(8'hA5, 8'h00, 8'h00, 1, 32, 0, 0);

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
